// File: rtl/systolic_drain_if.sv
// Result stream interface for systolic_drain: one signed word plus its 2x2 position,
// moved by a valid/ready handshake.
interface systolic_drain_if #(
  parameter int DW = 32
);
  logic signed [DW-1:0] out_data;
  logic [1:0]           out_idx;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/systolic_drain.sv
// systolic_drain: pulses the three push strobes of a 2x2 systolic array, captures its four
// results, and streams them out as (idx, word). Optional sticky overrun flag: DRAIN_OVERRUN_EN.
module systolic_drain #(
  parameter int PUSH_DELAY = 1,
  parameter int DW         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] Oc11,
  input  logic signed [DW-1:0] Oc12,
  input  logic signed [DW-1:0] Oc21,
  input  logic signed [DW-1:0] Oc22,
  output logic                 push11,
  output logic                 pushedge,
  output logic                 push22,
  output logic                 busy,
  output logic                 done,
`ifdef DRAIN_OVERRUN_EN
  output logic                 overrun,
`endif
  systolic_drain_if.master     drain
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    P11    = 3'd2,
    PEDGE  = 3'd3,
    P22    = 3'd4,
    CAP    = 3'd5,
    STREAM = 3'd6
  } state_t;

  localparam int        WAIT_LAST   = (PUSH_DELAY > 0) ? PUSH_DELAY - 1 : 0;
  localparam logic [3:0] WAIT_LAST_C = 4'(WAIT_LAST);

  state_t               state_r;
  state_t               state_s;
  logic [3:0]           wait_cnt_r;
  logic [1:0]           idx_r;
  logic signed [DW-1:0] word_r [4];
  logic                 accept_s;
  logic                 valid_s;
  logic signed [DW-1:0] data_s;
  logic [1:0]           oidx_s;

  assign accept_s = (state_r == STREAM) && drain.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (PUSH_DELAY > 0) ? WAIT : P11;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == WAIT_LAST_C) begin
          state_s = P11;
        end else begin
          state_s = WAIT;
        end
      end
      P11:   state_s = PEDGE;
      PEDGE: state_s = P22;
      P22:   state_s = CAP;
      CAP:   state_s = STREAM;
      STREAM: begin
        if (accept_s && (idx_r == 2'd3)) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Delay counter, stream index and result capture; each result is taken the cycle after its push
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_r <= 4'd0;
      idx_r      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        word_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= 4'd0;
      end
      if (state_r == CAP) begin
        idx_r <= 2'd0;
      end else if (accept_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (state_r == PEDGE) begin
        word_r[0] <= Oc11;
      end
      if (state_r == P22) begin
        word_r[1] <= Oc12;
        word_r[2] <= Oc21;
      end
      if (state_r == CAP) begin
        word_r[3] <= Oc22;
      end
    end
  end

  // Outputs decoded from the state register; done tracks acceptance of the last word
  always_comb begin
    push11   = (state_r == P11);
    pushedge = (state_r == PEDGE);
    push22   = (state_r == P22);
    busy     = (state_r != IDLE);
    done     = accept_s && (idx_r == 2'd3);
    if (state_r == STREAM) begin
      valid_s = 1'b1;
      data_s  = word_r[idx_r];
      oidx_s  = idx_r;
    end else begin
      valid_s = 1'b0;
      data_s  = {DW{1'b0}};
      oidx_s  = 2'd0;
    end
  end

  assign drain.out_valid = valid_s;
  assign drain.out_data  = data_s;
  assign drain.out_idx   = oidx_s;

`ifdef DRAIN_OVERRUN_EN
  logic overrun_r;

  // Sticky flag for a start that arrives while a drain is in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (start && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end
  end

  assign overrun = overrun_r;
`endif

endmodule
